// File: rtl/register_updown_param.sv
// WIDTH-bit up/down counter register with load, variable step and [LO,HI] bounds.
// Wraps or saturates at the bounds and keeps sticky overflow/underflow flags.
module register_updown_param #(
    parameter int WIDTH     = 8,
    parameter int LO        = 0,
    parameter int HI        = 2**WIDTH - 1,
    parameter int RESET_VAL = LO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    // Bound arithmetic is one bit wider so that out+step and out+R never truncate.
    localparam logic [WIDTH-1:0] LO_W  = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_W  = WIDTH'(HI);
    localparam logic [WIDTH:0]   LO_X  = (WIDTH+1)'(LO);
    localparam logic [WIDTH:0]   HI_X  = (WIDTH+1)'(HI);
    localparam logic [WIDTH:0]   R_X   = (WIDTH+1)'(HI - LO + 1);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] out_reg, out_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    logic [WIDTH:0] out_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] step_eff;
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] lo_plus_step;

    assign out_x        = {1'b0, out_reg};
    assign step_x       = {1'b0, step};
    // A step larger than the range is clamped so a single wrap always lands in bounds.
    assign step_eff     = (step_x > R_X) ? R_X : step_x;
    assign sum_x        = out_x + step_eff;
    assign lo_plus_step = LO_X + step_eff;

    always_comb begin
        out_next = out_reg;
        ovf_next = clr_flags ? 1'b0 : ovf_reg;
        unf_next = clr_flags ? 1'b0 : unf_reg;
        if (ld) begin
            if (in < LO_W)
                out_next = LO_W;
            else if (in > HI_W)
                out_next = HI_W;
            else
                out_next = in;
        end else if (inc) begin
            if (sum_x > HI_X) begin
                ovf_next = 1'b1;
                out_next = sat_mode ? HI_W : WIDTH'(sum_x - R_X);
            end else begin
                out_next = WIDTH'(sum_x);
            end
        end else if (dec) begin
            // out-step < LO is tested as out < LO+step to stay unsigned.
            if (out_x < lo_plus_step) begin
                unf_next = 1'b1;
                out_next = sat_mode ? LO_W : WIDTH'(out_x + R_X - step_eff);
            end else begin
                out_next = WIDTH'(out_x - step_eff);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= RST_W;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    assign out    = out_reg;
    assign ovf    = ovf_reg;
    assign unf    = unf_reg;
    assign at_max = (out_reg == HI_W);
    assign at_min = (out_reg == LO_W);

endmodule

// File: tb/tb_register_updown_param.sv
// Scoreboard bench for register_updown_param with WIDTH=8, LO=10, HI=20, RESET_VAL=10.
// Each test task queues its expected results and checks them as the DUT updates.
module tb_register_updown_param;

    logic       clk = 1'b0;
    logic       rst, ld, inc, dec, sat_mode, clr_flags;
    logic [7:0] in, step;
    logic [7:0] out;
    logic       at_max, at_min, ovf, unf;

    int vec_count  = 0;
    int miss_count = 0;

    // Stimulus: rst ld inc dec in step sat clr
    typedef struct packed {
        logic       rst;
        logic       ld;
        logic       inc;
        logic       dec;
        logic [7:0] in;
        logic [7:0] step;
        logic       sat;
        logic       clr;
    } stim_t;

    // Expected: out at_max at_min ovf unf
    typedef struct packed {
        logic [7:0] out;
        logic       at_max;
        logic       at_min;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];

    register_updown_param #(
        .WIDTH(8), .LO(10), .HI(20), .RESET_VAL(10)
    ) dut (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec),
        .in(in), .step(step), .sat_mode(sat_mode), .clr_flags(clr_flags),
        .out(out), .at_max(at_max), .at_min(at_min), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

    task automatic drive(input stim_t s);
        rst       = s.rst;
        ld        = s.ld;
        inc       = s.inc;
        dec       = s.dec;
        in        = s.in;
        step      = s.step;
        sat_mode  = s.sat;
        clr_flags = s.clr;
    endtask

    function automatic stim_t mk(input logic r, input logic l, input logic i, input logic d,
                                 input logic [7:0] v, input logic [7:0] st,
                                 input logic sat, input logic clr);
        mk = '{rst: r, ld: l, inc: i, dec: d, in: v, step: st, sat: sat, clr: clr};
    endfunction

    function automatic exp_t mx(input logic [7:0] o, input logic mxf, input logic mnf,
                                input logic of, input logic uf);
        mx = '{out: o, at_max: mxf, at_min: mnf, ovf: of, unf: uf};
    endfunction

    task automatic test_reset();
        stim_t s[2];
        exp_t  e[2];
        exp_t  got, want;
        s[0] = mk(1, 1, 0, 0, 8'd15, 8'd0, 0, 0); e[0] = mx(8'd10, 0, 1, 0, 0);
        s[1] = mk(1, 0, 1, 0, 8'd0,  8'd3, 0, 0); e[1] = mx(8'd10, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = '{out: out, at_max: at_max, at_min: at_min, ovf: ovf, unf: unf};
            vec_count++;
            if (got !== want) begin
                miss_count++;
                $display("FAIL reset[%0d]: got out=%0d max=%b min=%b ovf=%b unf=%b, want out=%0d max=%b min=%b ovf=%b unf=%b",
                         i, got.out, got.at_max, got.at_min, got.ovf, got.unf,
                         want.out, want.at_max, want.at_min, want.ovf, want.unf);
            end else $display("reset[%0d] out=%0d ok", i, got.out);
        end
    endtask

    task automatic test_load();
        stim_t s[4];
        exp_t  e[4];
        exp_t  got, want;
        s[0] = mk(0, 1, 0, 0, 8'd25, 8'd0, 0, 0); e[0] = mx(8'd20, 1, 0, 0, 0);
        s[1] = mk(0, 1, 0, 0, 8'd3,  8'd0, 0, 0); e[1] = mx(8'd10, 0, 1, 0, 0);
        s[2] = mk(0, 1, 0, 0, 8'd15, 8'd0, 0, 0); e[2] = mx(8'd15, 0, 0, 0, 0);
        s[3] = mk(0, 0, 0, 0, 8'd99, 8'd4, 1, 0); e[3] = mx(8'd15, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = '{out: out, at_max: at_max, at_min: at_min, ovf: ovf, unf: unf};
            vec_count++;
            if (got !== want) begin
                miss_count++;
                $display("FAIL load[%0d]: got out=%0d max=%b min=%b ovf=%b unf=%b, want out=%0d max=%b min=%b ovf=%b unf=%b",
                         i, got.out, got.at_max, got.at_min, got.ovf, got.unf,
                         want.out, want.at_max, want.at_min, want.ovf, want.unf);
            end else $display("load[%0d] out=%0d ok", i, got.out);
        end
    endtask

    task automatic test_wrap();
        stim_t s[4];
        exp_t  e[4];
        exp_t  got, want;
        s[0] = mk(0, 1, 0, 0, 8'd18, 8'd0, 0, 0); e[0] = mx(8'd18, 0, 0, 0, 0);
        s[1] = mk(0, 0, 1, 0, 8'd0,  8'd5, 0, 0); e[1] = mx(8'd12, 0, 0, 1, 0);
        s[2] = mk(0, 0, 0, 1, 8'd0,  8'd4, 0, 0); e[2] = mx(8'd19, 0, 0, 1, 1);
        s[3] = mk(0, 0, 0, 0, 8'd0,  8'd0, 0, 1); e[3] = mx(8'd19, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = '{out: out, at_max: at_max, at_min: at_min, ovf: ovf, unf: unf};
            vec_count++;
            if (got !== want) begin
                miss_count++;
                $display("FAIL wrap[%0d]: got out=%0d max=%b min=%b ovf=%b unf=%b, want out=%0d max=%b min=%b ovf=%b unf=%b",
                         i, got.out, got.at_max, got.at_min, got.ovf, got.unf,
                         want.out, want.at_max, want.at_min, want.ovf, want.unf);
            end else $display("wrap[%0d] out=%0d ok", i, got.out);
        end
    endtask

    task automatic test_saturate();
        stim_t s[6];
        exp_t  e[6];
        exp_t  got, want;
        s[0] = mk(0, 1, 0, 0, 8'd18, 8'd0,  1, 0); e[0] = mx(8'd18, 0, 0, 0, 0);
        s[1] = mk(0, 0, 1, 0, 8'd0,  8'd5,  1, 0); e[1] = mx(8'd20, 1, 0, 1, 0);
        s[2] = mk(0, 0, 1, 0, 8'd0,  8'd5,  1, 0); e[2] = mx(8'd20, 1, 0, 1, 0);
        s[3] = mk(0, 0, 0, 1, 8'd0,  8'd15, 1, 0); e[3] = mx(8'd10, 0, 1, 1, 1);
        s[4] = mk(0, 0, 0, 1, 8'd0,  8'd1,  1, 0); e[4] = mx(8'd10, 0, 1, 1, 1);
        s[5] = mk(0, 0, 0, 0, 8'd0,  8'd0,  1, 1); e[5] = mx(8'd10, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = '{out: out, at_max: at_max, at_min: at_min, ovf: ovf, unf: unf};
            vec_count++;
            if (got !== want) begin
                miss_count++;
                $display("FAIL saturate[%0d]: got out=%0d max=%b min=%b ovf=%b unf=%b, want out=%0d max=%b min=%b ovf=%b unf=%b",
                         i, got.out, got.at_max, got.at_min, got.ovf, got.unf,
                         want.out, want.at_max, want.at_min, want.ovf, want.unf);
            end else $display("saturate[%0d] out=%0d ok", i, got.out);
        end
    endtask

    task automatic test_priority();
        stim_t s[5];
        exp_t  e[5];
        exp_t  got, want;
        s[0] = mk(0, 1, 1, 1, 8'd14, 8'd2, 0, 0); e[0] = mx(8'd14, 0, 0, 0, 0);
        s[1] = mk(0, 0, 1, 1, 8'd0,  8'd2, 0, 0); e[1] = mx(8'd16, 0, 0, 0, 0);
        s[2] = mk(0, 0, 1, 0, 8'd0,  8'd0, 0, 0); e[2] = mx(8'd16, 0, 0, 0, 0);
        s[3] = mk(0, 0, 0, 1, 8'd0,  8'd0, 1, 0); e[3] = mx(8'd16, 0, 0, 0, 0);
        s[4] = mk(0, 0, 0, 1, 8'd0,  8'd3, 0, 0); e[4] = mx(8'd13, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = '{out: out, at_max: at_max, at_min: at_min, ovf: ovf, unf: unf};
            vec_count++;
            if (got !== want) begin
                miss_count++;
                $display("FAIL priority[%0d]: got out=%0d max=%b min=%b ovf=%b unf=%b, want out=%0d max=%b min=%b ovf=%b unf=%b",
                         i, got.out, got.at_max, got.at_min, got.ovf, got.unf,
                         want.out, want.at_max, want.at_min, want.ovf, want.unf);
            end else $display("priority[%0d] out=%0d ok", i, got.out);
        end
    endtask

    task automatic test_clr_flags();
        stim_t s[6];
        exp_t  e[6];
        exp_t  got, want;
        s[0] = mk(0, 1, 0, 0, 8'd19, 8'd0, 0, 0); e[0] = mx(8'd19, 0, 0, 0, 0);
        s[1] = mk(0, 0, 1, 0, 8'd0,  8'd5, 0, 0); e[1] = mx(8'd13, 0, 0, 1, 0);
        s[2] = mk(0, 0, 1, 0, 8'd0,  8'd9, 0, 1); e[2] = mx(8'd11, 0, 0, 1, 0);
        s[3] = mk(0, 0, 0, 0, 8'd0,  8'd0, 0, 1); e[3] = mx(8'd11, 0, 0, 0, 0);
        s[4] = mk(0, 0, 0, 1, 8'd0,  8'd2, 0, 1); e[4] = mx(8'd20, 1, 0, 0, 1);
        s[5] = mk(0, 0, 1, 0, 8'd0,  8'd0, 0, 1); e[5] = mx(8'd20, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = '{out: out, at_max: at_max, at_min: at_min, ovf: ovf, unf: unf};
            vec_count++;
            if (got !== want) begin
                miss_count++;
                $display("FAIL clr_flags[%0d]: got out=%0d max=%b min=%b ovf=%b unf=%b, want out=%0d max=%b min=%b ovf=%b unf=%b",
                         i, got.out, got.at_max, got.at_min, got.ovf, got.unf,
                         want.out, want.at_max, want.at_min, want.ovf, want.unf);
            end else $display("clr_flags[%0d] out=%0d ok", i, got.out);
        end
    endtask

    // Oversized steps clamp to the range (11), then reset must discard a busy cycle.
    task automatic test_step_clamp_and_rst();
        stim_t s[5];
        exp_t  e[5];
        exp_t  got, want;
        s[0] = mk(0, 1, 0, 0, 8'd15, 8'd0,   0, 0); e[0] = mx(8'd15, 0, 0, 0, 0);
        s[1] = mk(0, 0, 1, 0, 8'd0,  8'd200, 0, 0); e[1] = mx(8'd15, 0, 0, 1, 0);
        s[2] = mk(0, 0, 0, 1, 8'd0,  8'd255, 0, 0); e[2] = mx(8'd15, 0, 0, 1, 1);
        s[3] = mk(0, 0, 1, 0, 8'd0,  8'd200, 1, 0); e[3] = mx(8'd20, 1, 0, 1, 1);
        s[4] = mk(1, 1, 1, 0, 8'd17, 8'd3,   0, 1); e[4] = mx(8'd10, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = '{out: out, at_max: at_max, at_min: at_min, ovf: ovf, unf: unf};
            vec_count++;
            if (got !== want) begin
                miss_count++;
                $display("FAIL clamp_rst[%0d]: got out=%0d max=%b min=%b ovf=%b unf=%b, want out=%0d max=%b min=%b ovf=%b unf=%b",
                         i, got.out, got.at_max, got.at_min, got.ovf, got.unf,
                         want.out, want.at_max, want.at_min, want.ovf, want.unf);
            end else $display("clamp_rst[%0d] out=%0d ok", i, got.out);
        end
    endtask

    initial begin
        drive(mk(1, 0, 0, 0, 8'd0, 8'd0, 0, 0));
        @(negedge clk);
        test_reset();
        test_load();
        test_wrap();
        test_saturate();
        test_priority();
        test_clr_flags();
        test_step_clamp_and_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
